coverfloat_vector_driver: RTL
=============================

# coverfloat_vector_driver

Synthesizable stimulus source for the coverfloat flow. It buffers floating-point test vectors (operation, rounding mode, operands, expected result, expected flags) pushed by a loader and replays them onto the coverfloat interface as single-cycle `valid` pulses. It is the producer end of the interface that the coverage/check monitor samples on `posedge clk` when `valid` is high. A programmable inter-vector gap and start/stop control make it possible to pace transactions.

## Interface
- `OP_W`, 8: operation code width
- `RM_W`, 3: rounding-mode width
- `FLEN`, 128: operand/result width (covers quad precision)
- `FLAGS_W`, 5: IEEE exception flag width (NV, DZ, OF, UF, NX)
- `DEPTH`, 8: vector FIFO depth; must be a power of 2 and at least 2
- `CNT_W`, 32: issued-vector counter width

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; begin replay
- `stop`  in  1  pulse; halt replay; FIFO contents are kept
- `flush`  in  1  pulse; discard all FIFO contents
- `gap`  in  8  idle cycles inserted after each issued vector
- `in_valid`  in  1  loader offers a vector
- `in_ready`  out  1  FIFO can accept a vector
- `in_vec`  in  `$bits(cf_vector_t)`  offered vector
- `out_valid`  out  1  drives the interface `valid`
- `out_vec`  out  `$bits(cf_vector_t)`  drives the interface op/rm/a/b/c/result/flags fields
- `busy`  out  1  FSM is not in IDLE
- `issued_count`  out  `CNT_W`  number of vectors issued since reset

## Operation
- A push happens when `in_valid && in_ready` is true at a rising edge. `in_ready = !full` (combinational).
- FSM states are IDLE, RUN and GAP.
  - IDLE to RUN: on `start`.
  - RUN with FIFO non-empty: pop the head, register it to `out_vec`, and set `out_valid=1` for exactly one cycle. The current `gap` value is latched into the gap counter at this point. If latched gap is greater than 0, go to GAP; otherwise stay in RUN.
  - RUN with FIFO empty: stay in RUN with `out_valid=0`. This is not an error.
  - GAP: decrement the counter each cycle. When the counter reaches 0, return to RUN.
  - Any state to IDLE: on `stop`. `stop` has priority over an issue in the same cycle, so no vector is popped in that cycle.
- `start` while already in RUN or GAP is ignored. `start` and `stop` in the same cycle resolve to `stop`.
- `flush` empties the FIFO in one cycle and does not change the FSM state. A push in the same cycle as `flush` is dropped. `flush` also suppresses any pop in that cycle.
- A push and a pop in the same cycle are allowed when the FIFO is neither empty nor full. In that case the occupancy is unchanged.
- A push into an empty FIFO cannot be popped in the same cycle.
- `issued_count` increments on every issued vector and wraps modulo 2^CNT_W.
- The FIFO read and write pointers are `$clog2(DEPTH)+1` bits wide; the extra MSB distinguishes full from empty. Pointers wrap naturally.

## Timing
- Reset values:
  - `out_valid=0`, `out_vec='0`, `busy=0`, `issued_count=0`
  - FIFO empty, so `in_ready=1`
  - FSM in IDLE, gap counter = 0
- Latency: a vector pushed at edge k into an empty FIFO, with the FSM in RUN, appears as `out_valid=1` after edge k+1.
- Throughput:
  - With gap=0, one vector per cycle.
  - With gap=g, one vector every g+1 cycles.
- `out_vec` holds its last value while `out_valid=0`.
- Reset asserted mid-operation:
  - The FIFO is cleared.
  - Any `out_valid` pulse in progress is dropped at the next edge.
  - The counter is cleared.

## Structure
- Shared `coverfloat_pkg` holds:
  - `cf_vector_t`: packed struct of op, rm, a, b, c, result, flags
  - `cf_drv_state_e` enum: IDLE, RUN, GAP
  - default width constants
- Sub-module `coverfloat_vector_fifo`: synchronous FIFO with push, pop, flush, full, empty and registered read data. The FSM, gap counter and issue counter sit in the top module.

## Test plan
- Reset, then 4 pushes with gap=0, then `start` → 4 consecutive `out_valid` cycles, vectors in push order, `issued_count=4`.
- Push 3 vectors with gap=2, then `start` → `out_valid` pulses 3 cycles apart, `busy=1` throughout.
- Fill the FIFO with `DEPTH` vectors while in IDLE → `in_ready=0`. A 9th `in_valid` is not accepted. After `start` and one issue, `in_ready=1`.
- `stop` asserted during GAP with 2 vectors left → IDLE, no further `out_valid`. Next `start` issues the remaining 2 vectors unchanged.
- `flush` with 5 vectors queued while in RUN → no further `out_valid`, `in_ready=1`, `issued_count` unchanged.
- `rst` asserted for one cycle mid-stream → all outputs return to their reset values at the next edge. A subsequent push followed by `start` issues that new vector first.

Source files
------------

// File: rtl/coverfloat_pkg.sv
// Shared types and default widths for the coverfloat stimulus path.
package coverfloat_pkg;

  localparam int CF_OP_W    = 8;
  localparam int CF_RM_W    = 3;
  localparam int CF_FLEN    = 128;
  localparam int CF_FLAGS_W = 5;
  localparam int CF_DEPTH   = 8;
  localparam int CF_CNT_W   = 32;
  localparam int CF_GAP_W   = 8;

  // One test vector as seen on the coverfloat interface.
  typedef struct packed {
    logic [CF_OP_W-1:0]    op;
    logic [CF_RM_W-1:0]    rm;
    logic [CF_FLEN-1:0]    a;
    logic [CF_FLEN-1:0]    b;
    logic [CF_FLEN-1:0]    c;
    logic [CF_FLEN-1:0]    result;
    logic [CF_FLAGS_W-1:0] flags;
  } cf_vector_t;

  localparam int CF_VEC_W = $bits(cf_vector_t);

  // Replay sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } cf_drv_state_e;

endpackage

// File: rtl/coverfloat_vector_fifo.sv
// Synchronous vector FIFO with flush and a registered read-data stage.
// Pointers carry one extra MSB so full and empty can be told apart.
module coverfloat_vector_fifo
  import coverfloat_pkg::*;
#(
  parameter int DEPTH = CF_DEPTH
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  cf_vector_t i_wr_data,
  input  logic       i_pop,
  input  logic       i_flush,
  output cf_vector_t o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  cf_vector_t r_mem [DEPTH];
  cf_vector_t r_rd_data;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = i_push && !o_full && !i_flush;
  assign w_pop     = i_pop && !o_empty && !i_flush;
  assign o_rd_data = r_rd_data;

  // Storage array: written on every accepted push, never reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  // Pointer bookkeeping and read register; flush wins over push and pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_data <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coverfloat_vector_driver.sv
// Replays buffered test vectors onto the coverfloat interface as one-cycle
// valid pulses, with a programmable idle gap and start/stop/flush control.
module coverfloat_vector_driver
  import coverfloat_pkg::*;
#(
  parameter int DEPTH = CF_DEPTH,
  parameter int CNT_W = CF_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_flush,
  input  logic [CF_GAP_W-1:0] i_gap,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  cf_vector_t          i_in_vec,
  output logic                o_out_valid,
  output cf_vector_t          o_out_vec,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_issued_count
);

  cf_drv_state_e       r_state;
  logic [CF_GAP_W-1:0] r_gap_cnt;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_issued_count;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  cf_vector_t          w_rd_data;

  // A vector leaves the FIFO only in RUN, and never when stop or flush is
  // asserted in the same cycle.
  assign w_pop = (r_state == RUN) && !w_empty && !i_stop && !i_flush;

  coverfloat_vector_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (i_in_valid),
    .i_wr_data (i_in_vec),
    .i_pop     (w_pop),
    .i_flush   (i_flush),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign o_in_ready     = !w_full;
  assign o_out_vec      = w_rd_data;
  assign o_out_valid    = r_out_valid;
  assign o_busy         = (r_state != IDLE);
  assign o_issued_count = r_issued_count;

  // Sequencer: state, gap counter, valid pulse and issue counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_gap_cnt      <= '0;
      r_out_valid    <= 1'b0;
      r_issued_count <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (i_stop) begin
        r_state   <= IDLE;
        r_gap_cnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_start) begin
              r_state <= RUN;
            end
          end
          RUN: begin
            if (w_pop) begin
              r_out_valid    <= 1'b1;
              r_issued_count <= r_issued_count + 1'b1;
              r_gap_cnt      <= i_gap;
              if (i_gap != '0) begin
                r_state <= GAP;
              end
            end
          end
          GAP: begin
            if (r_gap_cnt <= 1) begin
              r_gap_cnt <= '0;
              r_state   <= RUN;
            end else begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end
          end
          default: begin
            r_state   <= IDLE;
            r_gap_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
